mem_readout_sched: RTL and testbench
====================================

# mem_readout_sched

Per-BX readout scheduler for the registered 20-port memory readout mux. On each BX start it emits the header select (code 5'b11111, with BX), then walks the enabled input memories in ascending port order and issues one read address per cycle for every stored entry. It drives the mux `sel` delayed to match the memory read latency and enforces a per-BX slot budget. It sits between the BX timing logic, the memories' entry counters and the mux.

## Interface

Parameters:
- `NPORTS`, 20, number of memory ports (1..20); port i maps to mux code i+1.
- `PORT_MASK`, 20'hFFFFF, bit i = 1 enables port i; disabled ports are never read.
- `MEM_LATENCY`, 2, memory read latency in cycles, from registered `read_add` to data at the mux input (1..4).
- `MAX_SLOTS`, 100, maximum slots per BX, header included (2..255).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse marking a new BX.
- `BX_in`  in  3  BX number, sampled with `start`.
- `nent`  in  6*NPORTS  entry count of port i in bits [6i+5:6i], sampled with `start`.
- `read_add`  out  6  read address for the currently read port.
- `read_en`  out  NPORTS  one-hot read enable, aligned with `read_add`.
- `sel`  out  5  mux select, delayed MEM_LATENCY cycles from the internal slot.
- `BX`  out  3  BX for the mux header, aligned with `sel`.
- `busy`  out  1  high from the header slot through the last issued slot.
- `done`  out  1  one-cycle pulse after the final slot of a BX.

## Operation

- States: IDLE, HEADER, SCAN.
- IDLE
  - Internal slot code = 0; `read_en` = 0.
  - `start` moves to HEADER.
- On the `start` edge:
  - Snapshot `nent` for enabled ports and latch `BX_in`.
  - pending mask = PORT_MASK & (nent != 0).
  - Slot counter = 0.
- HEADER, one cycle:
  - Slot code 5'b11111; `read_en` = 0; slot counter increments.
  - Next state is SCAN, or IDLE with `done` if pending is empty.
- SCAN, each cycle:
  - Current port p is the lowest set bit of pending (priority encoder). Empty and masked ports cost zero cycles.
  - Drive `read_add` = entry index (0..nent[p]-1), `read_en`[p] = 1, slot code = p+1.
  - After the entry index reaches nent[p]-1: clear bit p, reset the index to 0, and move to the next port on the next cycle with no gap.
- Termination:
  - Pending empty after a slot: go to IDLE and pulse `done`.
  - Slot counter reaches MAX_SLOTS after a slot: truncate remaining entries, go to IDLE and pulse `done`.
- `start` while HEADER or SCAN:
  - Abort the current BX with no `done`; re-snapshot and enter HEADER next cycle.
  - Slots already in the delay pipe still drain to `sel`.
- `start` on the final slot's edge: the new BX wins and `done` is suppressed.
- Output delay:
  - `sel` and `BX` pass through a MEM_LATENCY-deep shift register fed by the slot code and latched BX.
  - Idle slots propagate as code 0, which makes the mux output zero.
- Arithmetic:
  - Entry index and `nent` are unsigned 6-bit.
  - Slot counter is 8-bit; it never exceeds MAX_SLOTS.

## Timing

- Reset (async assert, sync release):
  - `sel` = 0, `BX` = 0, `read_add` = 0, `read_en` = 0, `busy` = 0, `done` = 0.
  - State IDLE; delay pipe cleared to 0.
- `start` sampled at edge E0: header slot internal after E0; `sel` = 5'b11111 after E0+MEM_LATENCY.
- First read: `read_add`/`read_en` after E0+1; matching `sel` after E0+1+MEM_LATENCY, the same edge its data is valid at the mux.
- Throughput: one slot per cycle. A BX with N total entries and no truncation takes 1+N slots; `done` follows one cycle after the last slot.
- `busy` is high exactly during HEADER and SCAN cycles.
- Reset mid-scan: immediate abort, pipe cleared, no `done`.

## Test plan

- MEM_LATENCY=2; nent[0]=2, nent[7]=1, others 0; `start` with BX_in=5.
  - `sel` sequence 11111, 00001, 00001, 01000, then 0.
  - `BX`=5 with the header.
  - `read_add` 0, 1, 0.
  - `done` once, 4 cycles after start.
- All nent=0, `start` → header only, `done` the next cycle, no `read_en`.
- PORT_MASK=20'h00080; nent[0]=5, nent[7]=3 → only port 7 read (`sel` 01000 ×3); port 0 ignored.
- MAX_SLOTS=10; nent[19]=63 → header plus 9 reads of port 19 (`sel` 10100, addresses 0..8), then `done`.
- `start` again mid-scan with BX_in=6 → current BX stops with no `done`; new header carries BX=6; previously issued slots still drain to `sel` in order.
- Assert `reset` mid-scan → all outputs 0 immediately; the next `start` behaves as the first scenario.

Source files
------------

// File: rtl/mem_readout_sched.sv
// Per-BX readout scheduler: emits a header slot, then one read per stored entry of every
// enabled port in ascending order, with the mux select delayed to match memory latency.
module mem_readout_sched #(
    parameter int          NPORTS      = 20,
    parameter logic [19:0] PORT_MASK   = 20'hFFFFF,
    parameter int          MEM_LATENCY = 2,
    parameter int          MAX_SLOTS   = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            BX_in,
    input  logic [6*NPORTS-1:0]   nent,
    output logic [5:0]            read_add,
    output logic [NPORTS-1:0]     read_en,
    output logic [4:0]            sel,
    output logic [2:0]            BX,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [NPORTS-1:0] MASK    = PORT_MASK[NPORTS-1:0];
    localparam logic [7:0]        MAX_CNT = 8'(MAX_SLOTS);
    localparam logic [4:0]        HDR_CODE = 5'b11111;

    state_t                state_q, state_d;
    logic [NPORTS-1:0]     pending_q, pending_d;
    logic [6*NPORTS-1:0]   nent_q, nent_d;
    logic [5:0]            idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            bx_q, bx_d;
    logic                  done_q, done_d;
    logic [4:0]            sel_pipe_q [MEM_LATENCY];
    logic [4:0]            sel_pipe_d [MEM_LATENCY];
    logic [2:0]            bx_pipe_q  [MEM_LATENCY];
    logic [2:0]            bx_pipe_d  [MEM_LATENCY];

    logic [4:0]            cur_port;
    logic [5:0]            cur_n;
    logic [NPORTS-1:0]     cur_oh;
    logic [4:0]            slot_code;
    logic [7:0]            cnt_inc;

    // Priority encoder: lowest pending port wins, so empty/masked ports cost no cycles.
    always_comb begin
        cur_port = 5'd0;
        cur_n    = 6'd0;
        cur_oh   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                cur_port  = 5'(i);
                cur_n     = nent_q[i*6 +: 6];
                cur_oh    = '0;
                cur_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        nent_d    = nent_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bx_d      = bx_q;
        done_d    = 1'b0;
        slot_code = 5'd0;
        read_add  = 6'd0;
        read_en   = '0;
        cnt_inc   = cnt_q + 8'd1;

        case (state_q)
            HEADER: begin
                slot_code = HDR_CODE;
                cnt_d     = cnt_inc;
                if (pending_q == '0 || cnt_inc == MAX_CNT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                slot_code = cur_port + 5'd1;
                read_add  = idx_q;
                read_en   = cur_oh;
                cnt_d     = cnt_inc;
                if (idx_q == cur_n - 6'd1) begin
                    pending_d = pending_q & ~cur_oh;
                    idx_d     = 6'd0;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
                if (pending_d == '0 || cnt_inc == MAX_CNT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        // A new BX pre-empts whatever is in flight, including the final slot's done.
        if (start) begin
            nent_d = nent;
            bx_d   = BX_in;
            for (int i = 0; i < NPORTS; i++) begin
                pending_d[i] = MASK[i] & (nent[i*6 +: 6] != 6'd0);
            end
            cnt_d   = 8'd0;
            idx_d   = 6'd0;
            state_d = HEADER;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        sel_pipe_d[0] = slot_code;
        bx_pipe_d[0]  = bx_q;
        for (int k = 1; k < MEM_LATENCY; k++) begin
            sel_pipe_d[k] = sel_pipe_q[k-1];
            bx_pipe_d[k]  = bx_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            nent_q    <= '0;
            idx_q     <= 6'd0;
            cnt_q     <= 8'd0;
            bx_q      <= 3'd0;
            done_q    <= 1'b0;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                sel_pipe_q[k] <= 5'd0;
                bx_pipe_q[k]  <= 3'd0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            nent_q    <= nent_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            bx_q      <= bx_d;
            done_q    <= done_d;
            for (int k = 0; k < MEM_LATENCY; k++) begin
                sel_pipe_q[k] <= sel_pipe_d[k];
                bx_pipe_q[k]  <= bx_pipe_d[k];
            end
        end
    end

    assign sel  = sel_pipe_q[MEM_LATENCY-1];
    assign BX   = bx_pipe_q[MEM_LATENCY-1];
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mem_readout_sched.sv
// Bench for mem_readout_sched: three instances (default, port-masked, slot-limited with
// latency 3) share stimulus; every slot is checked for value and exact cycle.
module tb_mem_readout_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   bx_in;
    logic [119:0] nent;

    logic [5:0]   read_add_w [3];
    logic [19:0]  read_en_w  [3];
    logic [4:0]   sel_w      [3];
    logic [2:0]   bx_w       [3];
    logic         busy_w     [3];
    logic         done_w     [3];

    int cyc = 0;
    int start_cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt [3];
    int done_at  [3];
    int busy_cyc [3];

    int          lat_c  [3] = '{2, 2, 3};
    int          max_c  [3] = '{100, 100, 10};
    logic [19:0] mask_c [3] = '{20'hFFFFF, 20'h00080, 20'hFFFFF};

    // {expected cycle, sel, BX} and {expected cycle, read_add, read_en}
    logic [39:0] exp_out_q [3][$];
    logic [57:0] exp_rd_q  [3][$];

    typedef struct {
        logic [119:0] nent;
        logic [2:0]   bx;
        int           exp_a;
        int           exp_m;
        int           exp_s;
    } vec_t;
    vec_t vecs [5];

    mem_readout_sched #(.NPORTS(20), .PORT_MASK(20'hFFFFF), .MEM_LATENCY(2), .MAX_SLOTS(100)) dut_a (
        .clk(clk), .reset(reset), .start(start), .BX_in(bx_in), .nent(nent),
        .read_add(read_add_w[0]), .read_en(read_en_w[0]), .sel(sel_w[0]), .BX(bx_w[0]),
        .busy(busy_w[0]), .done(done_w[0]));

    mem_readout_sched #(.NPORTS(20), .PORT_MASK(20'h00080), .MEM_LATENCY(2), .MAX_SLOTS(100)) dut_m (
        .clk(clk), .reset(reset), .start(start), .BX_in(bx_in), .nent(nent),
        .read_add(read_add_w[1]), .read_en(read_en_w[1]), .sel(sel_w[1]), .BX(bx_w[1]),
        .busy(busy_w[1]), .done(done_w[1]));

    mem_readout_sched #(.NPORTS(20), .PORT_MASK(20'hFFFFF), .MEM_LATENCY(3), .MAX_SLOTS(10)) dut_s (
        .clk(clk), .reset(reset), .start(start), .BX_in(bx_in), .nent(nent),
        .read_add(read_add_w[2]), .read_en(read_en_w[2]), .sel(sel_w[2]), .BX(bx_w[2]),
        .busy(busy_w[2]), .done(done_w[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d got %h want %h (cycle %0d)", name, k, got, want, cyc);
        end
    endtask

    // Monitor: compare every emitted slot and read against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (sel_w[k] != 5'd0) begin
                    if (exp_out_q[k].size() == 0) begin
                        check("sel_unexpected", k, 64'({32'(cyc), sel_w[k], bx_w[k]}), 64'd0);
                    end else begin
                        check("sel_bx", k, 64'({32'(cyc), sel_w[k], bx_w[k]}), 64'(exp_out_q[k].pop_front()));
                    end
                end
                if (read_en_w[k] != 20'd0) begin
                    if (exp_rd_q[k].size() == 0) begin
                        check("read_unexpected", k, 64'({32'(cyc), read_add_w[k], read_en_w[k]}), 64'd0);
                    end else begin
                        check("read", k, 64'({32'(cyc), read_add_w[k], read_en_w[k]}), 64'(exp_rd_q[k].pop_front()));
                    end
                end
                if (busy_w[k]) busy_cyc[k]++;
                if (done_w[k]) begin
                    done_cnt[k]++;
                    done_at[k] = cyc - start_cyc;
                end
            end
        end
    end

    function automatic logic [119:0] put(input logic [119:0] v, input int p, input int n);
        logic [119:0] r;
        r = v;
        r[p*6 +: 6] = 6'(n);
        return r;
    endfunction

    task automatic push_model(input int k, input logic [119:0] nv, input logic [2:0] bv, input int limit);
        int n;
        logic [19:0] oh;
        n = 1;
        exp_out_q[k].push_back({32'(start_cyc + lat_c[k]), 5'b11111, bv});
        for (int p = 0; p < 20; p++) begin
            if (mask_c[k][p]) begin
                for (int e = 0; e < int'(nv[p*6 +: 6]); e++) begin
                    if (n < max_c[k] && n < limit) begin
                        oh = 20'd0;
                        oh[p] = 1'b1;
                        exp_out_q[k].push_back({32'(start_cyc + lat_c[k] + n), 5'(p + 1), bv});
                        exp_rd_q[k].push_back({32'(start_cyc + n), 6'(e), oh});
                        n++;
                    end
                end
            end
        end
    endtask

    task automatic start_bx(input logic [119:0] nv, input logic [2:0] bv, input int limit);
        @(posedge clk);
        #1;
        start = 1'b1;
        nent = nv;
        bx_in = bv;
        start_cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            done_cnt[k] = 0;
            busy_cyc[k] = 0;
            done_at[k] = -1;
            push_model(k, nv, bv, limit);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_bx(input int ea, input int em, input int es, input int busy_extra);
        int ex [3];
        ex = '{ea, em, es};
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            if (done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0) break;
        end
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("done_count", k, 64'(done_cnt[k]), 64'd1);
            check("done_cycle", k, 64'(done_at[k]), 64'(ex[k]));
            check("busy_cycles", k, 64'(busy_cyc[k]), 64'(ex[k] + busy_extra));
            check("sel_missing", k, 64'(exp_out_q[k].size()), 64'd0);
            check("read_missing", k, 64'(exp_rd_q[k].size()), 64'd0);
            exp_out_q[k].delete();
            exp_rd_q[k].delete();
        end
    endtask

    task automatic check_zero(input string name);
        for (int k = 0; k < 3; k++) begin
            check(name, k, 64'({sel_w[k], bx_w[k], read_add_w[k], read_en_w[k], busy_w[k], done_w[k]}), 64'd0);
        end
    endtask

    initial begin
        logic [119:0] v;
        int sum;
        int ea;
        int es;

        reset = 1'b0;
        start = 1'b0;
        nent = '0;
        bx_in = 3'd0;
        #1 reset = 1'b1;
        #2 check_zero("reset_state");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        v = put('0, 0, 2);
        v = put(v, 7, 1);
        vecs[0] = '{v, 3'd5, 4, 2, 4};
        vecs[1] = '{120'd0, 3'd2, 1, 1, 1};
        v = put('0, 0, 5);
        v = put(v, 7, 3);
        vecs[2] = '{v, 3'd1, 9, 4, 9};
        vecs[3] = '{put('0, 19, 63), 3'd7, 64, 1, 10};
        v = '0;
        for (int i = 0; i < 5; i++) v = put(v, i, i + 1);
        v = put(v, 7, 4);
        vecs[4] = '{v, 3'd3, 20, 5, 10};

        for (int i = 0; i < 5; i++) begin
            start_bx(vecs[i].nent, vecs[i].bx, 1000);
            finish_bx(vecs[i].exp_a, vecs[i].exp_m, vecs[i].exp_s, 0);
        end

        for (int i = 0; i < 4; i++) begin
            v = '0;
            sum = 0;
            for (int p = 0; p < 20; p++) begin
                int n;
                n = $urandom_range(0, 3 + 3 * i);
                v = put(v, p, n);
                sum += n;
            end
            ea = (1 + sum > 100) ? 100 : 1 + sum;
            es = (1 + sum > 10) ? 10 : 1 + sum;
            start_bx(v, 3'($urandom_range(0, 7)), 1000);
            finish_bx(ea, 1 + int'(v[7*6 +: 6]), es, 0);
        end

        // Restart after header plus one read: old slots drain, no done for the aborted BX.
        start_bx(vecs[0].nent, 3'd3, 2);
        start_bx(vecs[0].nent, 3'd6, 1000);
        finish_bx(4, 2, 4, 1);

        // Reset in the middle of a long scan.
        start_bx(vecs[3].nent, 3'd7, 1000);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_zero("reset_mid_scan");
        for (int k = 0; k < 3; k++) begin
            exp_out_q[k].delete();
            exp_rd_q[k].delete();
        end
        @(posedge clk);
        #1 reset = 1'b0;
        start_bx(vecs[0].nent, vecs[0].bx, 1000);
        finish_bx(4, 2, 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
